// File: rtl/gate_pkg.sv
// Shared types and constants for the unit deployment logic:
// unit lifecycle states, unit slot indices and the elixir cost of each card.
package gate_pkg;

  typedef enum logic [2:0] {
    HAND   = 3'd0,
    HELD   = 3'd1,
    LAUNCH = 3'd2,
    FIELD  = 3'd3,
    COOL   = 3'd4
  } unit_state_t;

  localparam int UNIT_AND  = 0;
  localparam int UNIT_OR   = 1;
  localparam int UNIT_NOT  = 2;
  localparam int UNIT_NERD = 3;

  // Entry [i] is the elixir cost of unit i: and=3, or=3, not=2, nerd=4.
  localparam logic [3:0][3:0] COST = {4'd4, 4'd2, 4'd3, 4'd3};

endpackage

// File: rtl/deploy_scheduler_if.sv
// Bundle between the keyboard/mouse decode (master) and the deploy scheduler (slave).
// The scheduler only gates on MouseX, so MouseY is carried but not part of its modport.
interface deploy_scheduler_if #(
  parameter int NUM_UNITS = 4
);
  logic                 frame_tick;
  logic [NUM_UNITS-1:0] card_sel;
  logic                 click_l;
  logic                 click_r;
  logic [9:0]           MouseX;
  logic [9:0]           MouseY;
  logic [NUM_UNITS-1:0] unit_infield;
  logic [NUM_UNITS-1:0] idle_o;
  logic [NUM_UNITS-1:0] instate_o;
  logic [NUM_UNITS-1:0] deploy_o;
  logic [3:0]           elixir;
  logic                 reject;

  modport master (
    output frame_tick, card_sel, click_l, click_r, MouseX, MouseY, unit_infield,
    input  idle_o, instate_o, deploy_o, elixir, reject
  );

  modport slave (
    input  frame_tick, card_sel, click_l, click_r, MouseX, unit_infield,
    output idle_o, instate_o, deploy_o, elixir, reject
  );
endinterface

// File: rtl/unit_slot_fsm.sv
// Lifecycle of one unit card, from hand to field and back via a frame-based cooldown.
//
//   state  | meaning
//   HAND   | card in hand, sprite held idle
//   HELD   | card picked up, sprite follows the mouse
//   LAUNCH | deploy level held until a vsync tick is seen
//   FIELD  | unit active on the field
//   COOL   | unit died, counting down frames before returning to hand
module unit_slot_fsm
  import gate_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 120
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic        grant,
  input  logic        cancel,
  input  logic        launch,
  input  logic        infield,
  output unit_state_t state,
  output logic        idle_o,
  output logic        instate_o,
  output logic        deploy_o
);

  localparam int CW = $clog2(COOLDOWN_FRAMES);

  unit_state_t   state_q, state_d;
  logic [CW-1:0] cool_q, cool_d;
  logic          infield_q;
  logic          infield_fall;

  assign infield_fall = infield_q & ~infield;
  assign state        = state_q;

  // Outputs are decoded from the next state so they appear with the state change.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= HAND;
      cool_q    <= '0;
      infield_q <= 1'b0;
      idle_o    <= 1'b1;
      instate_o <= 1'b0;
      deploy_o  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cool_q    <= cool_d;
      infield_q <= infield;
      idle_o    <= (state_d == HAND) || (state_d == COOL);
      instate_o <= (state_d == HELD);
      deploy_o  <= (state_d == LAUNCH);
    end
  end

  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    case (state_q)
      HAND: begin
        if (grant) state_d = HELD;
      end
      HELD: begin
        if (cancel)      state_d = HAND;
        else if (launch) state_d = LAUNCH;
      end
      LAUNCH: begin
        if (frame_tick) state_d = FIELD;
      end
      FIELD: begin
        if (infield_fall) begin
          state_d = COOL;
          cool_d  = CW'(COOLDOWN_FRAMES - 1);
        end
      end
      COOL: begin
        if (frame_tick) begin
          if (cool_q == '0) state_d = HAND;
          else              cool_d  = cool_q - 1'b1;
        end
      end
      default: state_d = HAND;
    endcase
  end

endmodule

// File: rtl/deploy_scheduler.sv
// Moves unit cards from hand to field: owns the elixir budget, the single held-card
// slot and reject generation; each unit's lifecycle lives in its own unit_slot_fsm.
module deploy_scheduler
  import gate_pkg::*;
#(
  parameter int NUM_UNITS       = 4,
  parameter int ELIXIR_MAX      = 10,
  parameter int REGEN_FRAMES    = 90,
  parameter int COOLDOWN_FRAMES = 120,
  parameter int DEPLOY_XMAX     = 319
) (
  input logic               Clk,
  input logic               reset_n,
  deploy_scheduler_if.slave bus
);

  localparam int         IW    = $clog2(NUM_UNITS);
  localparam int         RW    = $clog2(REGEN_FRAMES);
  localparam logic [9:0] XMAX  = 10'(DEPLOY_XMAX);
  localparam logic [3:0] EMAX  = 4'(ELIXIR_MAX);
  localparam logic [3:0] E_RST = 4'd5;

  unit_state_t          state [NUM_UNITS];
  logic [NUM_UNITS-1:0] grant, cancel, launch;
  logic [NUM_UNITS-1:0] idle_v, instate_v, deploy_v;

  logic [RW-1:0] regen_q;
  logic [3:0]    elixir_q, elixir_d, elixir_dec, debit;
  logic          regen_wrap;
  logic          reject_q, reject_d;
  logic          busy, held_any;
  logic [IW-1:0] held_idx, sel_idx;

  always_comb begin
    busy     = 1'b0;
    held_any = 1'b0;
    held_idx = '0;
    sel_idx  = '0;
    grant    = '0;
    cancel   = '0;
    launch   = '0;
    debit    = '0;
    reject_d = 1'b0;

    for (int i = 0; i < NUM_UNITS; i++) begin
      if (state[i] == HELD) begin
        held_any = 1'b1;
        held_idx = IW'(i);
      end
      if ((state[i] == HELD) || (state[i] == LAUNCH)) busy = 1'b1;
    end

    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (bus.card_sel[i]) sel_idx = IW'(i);
    end

    // Re-pressing the key of the card already held is silently ignored.
    if (|bus.card_sel) begin
      if ((state[sel_idx] == HAND) && !busy && (elixir_q >= COST[sel_idx]))
        grant[sel_idx] = 1'b1;
      else if (state[sel_idx] != HELD)
        reject_d = 1'b1;
    end

    if (held_any) begin
      if (bus.click_r) begin
        cancel[held_idx] = 1'b1;
      end else if (bus.click_l) begin
        if ((bus.MouseX <= XMAX) && (elixir_q >= COST[held_idx])) begin
          launch[held_idx] = 1'b1;
          debit            = COST[held_idx];
        end else begin
          reject_d = 1'b1;
        end
      end
    end
  end

  // Debit first, then regen, so a coincident pair yields elixir - cost + 1.
  assign regen_wrap = bus.frame_tick && (regen_q == RW'(REGEN_FRAMES - 1));
  assign elixir_dec = elixir_q - debit;
  assign elixir_d   = (regen_wrap && (elixir_dec < EMAX)) ? elixir_dec + 4'd1 : elixir_dec;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      regen_q  <= '0;
      elixir_q <= E_RST;
      reject_q <= 1'b0;
    end else begin
      if (bus.frame_tick) regen_q <= regen_wrap ? '0 : regen_q + 1'b1;
      elixir_q <= elixir_d;
      reject_q <= reject_d;
    end
  end

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_slot
    unit_slot_fsm #(
      .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
    ) u_slot (
      .Clk       (Clk),
      .reset_n   (reset_n),
      .frame_tick(bus.frame_tick),
      .grant     (grant[g]),
      .cancel    (cancel[g]),
      .launch    (launch[g]),
      .infield   (bus.unit_infield[g]),
      .state     (state[g]),
      .idle_o    (idle_v[g]),
      .instate_o (instate_v[g]),
      .deploy_o  (deploy_v[g])
    );
  end

  assign bus.idle_o    = idle_v;
  assign bus.instate_o = instate_v;
  assign bus.deploy_o  = deploy_v;
  assign bus.elixir    = elixir_q;
  assign bus.reject    = reject_q;

endmodule
